wide_add_sequencer: RTL
=======================

# wide_add_sequencer

Multi-cycle sequencer that adds two wide operands (nBITS*NSLICES bits) using a single external nBITS-wide carry-lookahead adder slice. It processes one nBITS slice per clock, least-significant first, and chains the carry through an internal register. It accepts requests and returns results over valid/ready handshakes. It sits between a requester and one shared adder instance, and is the only driver of that adder's inputs.

## Interface
- nBITS, 4, width of the external adder slice
- NSLICES, 4, slices per operation; W = nBITS*NSLICES (16 by default); NSLICES >= 2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_a  in  W  operand A
- req_b  in  W  operand B
- req_cin  in  1  carry-in for the whole operation
- ain  out  nBITS  to adder: current A slice
- bin  out  nBITS  to adder: current B slice
- cin  out  1  to adder: current chained carry
- sum  in  nBITS  from adder: slice sum, combinational from ain/bin/cin
- cout  in  1  from adder: slice carry-out
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  W  full-width sum
- rsp_cout  out  1  final carry-out
- rsp_ovf  out  1  two's-complement overflow of the W-bit add

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - If req_valid, capture req_a, req_b and req_cin into a_reg, b_reg and carry_reg; set idx=0; go to RUN.
  - req_a, req_b and req_cin are ignored when req_valid=0.
- RUN:
  - req_ready=0.
  - Drive ain=a_reg[idx*nBITS +: nBITS], bin=b_reg[idx*nBITS +: nBITS], cin=carry_reg.
  - Each cycle: res_reg[idx slice]<=sum, carry_reg<=cout, idx<=idx+1.
  - When idx==NSLICES-1 at the edge, go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum=res_reg; rsp_cout=carry_reg.
  - rsp_ovf = (a_reg[W-1]==b_reg[W-1]) && (res_reg[W-1]!=a_reg[W-1]).
  - On rsp_ready=1, go to IDLE.
  - rsp_* stay stable while rsp_ready=0.
- ain, bin and cin are 0 in IDLE and DONE, so the adder inputs are quiet outside RUN.
- rsp_sum, rsp_cout and rsp_ovf are 0 whenever rsp_valid=0.
- idx counter width is clog2(NSLICES), minimum 1 bit. idx never exceeds NSLICES-1 and does not wrap within an operation.
- No arithmetic is done internally except the overflow compare; all addition goes through the external adder.
- Reset (rst_n=0 at any edge, in any state): go to IDLE; clear a_reg, b_reg, res_reg, carry_reg and idx. Any in-flight operation is discarded with no response.
- Reset values: req_ready=1 from the first edge with rst_n=1; all other outputs are 0.

## Timing
- Request accepted at edge E0 (IDLE, req_valid=1).
- RUN occupies the cycles after edges E0..E(NSLICES-1); slice k is presented after edge Ek and captured at edge E(k+1).
- rsp_valid rises after edge E(NSLICES): latency NSLICES cycles from accept.
- Response completes on the first edge with rsp_valid=1 and rsp_ready=1; req_ready returns 1 on the following cycle.
- Minimum occupancy is NSLICES+1 cycles per operation; no overlap of operations.
- The adder path (ain/bin/cin to sum/cout) must settle within one clk period; the sequencer adds no pipeline stage on it.
- req_valid held while req_ready=0 is not an error; it is accepted once the block returns to IDLE.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, release.
  - Required: req_ready=1 and every other output 0.
  - Required: ain, bin and cin stay 0 with no request.
- Basic add, nBITS=4, NSLICES=4: a=0x1234, b=0x4321, cin=0.
  - Required: ain sequence 4,3,2,1 and bin sequence 1,2,3,4 on consecutive cycles.
  - Required: rsp_valid 4 cycles after accept, rsp_sum=0x5555, rsp_cout=0, rsp_ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1.
  - Required: cin=1 on every slice.
  - Required: rsp_sum=0x0000, rsp_cout=1, rsp_ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> rsp_sum=0x8000, rsp_cout=0, rsp_ovf=1.
- Backpressure: result 0x5555 pending, rsp_ready=0 for 3 cycles, req_valid=1 with a new request.
  - Required: rsp_* stable and req_ready=0 throughout.
  - Required: the new request is accepted the cycle after rsp_ready=1 handshake and yields its correct sum.
- Reset mid-operation: a=0x1234, b=0x4321, assert rst_n=0 while idx=2.
  - Required: next cycle IDLE, no rsp_valid pulse, all outputs at reset values.
  - Required: a following a=0x0001, b=0x0001 returns rsp_sum=0x0002.

Source files
------------

// File: rtl/wide_add_sequencer_if.sv
// Handshake and adder-slice bundle shared by the requester, the sequencer and the
// external nBITS adder. The slave modport is the sequencer's view.
interface wide_add_sequencer_if #(
    parameter int nBITS   = 4,
    parameter int NSLICES = 4
);
    localparam int W = nBITS * NSLICES;

    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic             req_cin;

    logic [nBITS-1:0] ain;
    logic [nBITS-1:0] bin;
    logic             cin;
    logic [nBITS-1:0] sum;
    logic             cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_sum;
    logic             rsp_cout;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready, sum, cout,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, ain, bin, cin
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready, sum, cout,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, ain, bin, cin
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// Adds two W-bit operands one nBITS slice per clock through a shared external adder,
// least-significant slice first, chaining the carry through r_carry.
module wide_add_sequencer #(
    parameter int nBITS   = 4,
    parameter int NSLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wide_add_sequencer_if.slave   bus
);
    localparam int W     = nBITS * NSLICES;
    localparam int IDX_W = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      w_off;
    logic             w_last;

    assign w_off  = 32'(r_idx) * 32'(nBITS);
    assign w_last = (r_idx == IDX_W'(NSLICES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_carry <= bus.req_cin;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_res[w_off +: nBITS] <= bus.sum;
                    r_carry               <= bus.cout;
                    // Hold on the last slice so idx never passes NSLICES-1.
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.ain       = '0;
        bus.bin       = '0;
        bus.cin       = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_sum   = '0;
        bus.rsp_cout  = 1'b0;
        bus.rsp_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                bus.ain = r_a[w_off +: nBITS];
                bus.bin = r_b[w_off +: nBITS];
                bus.cin = r_carry;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_sum   = r_res;
                bus.rsp_cout  = r_carry;
                bus.rsp_ovf   = (r_a[W-1] == r_b[W-1]) && (r_res[W-1] != r_a[W-1]);
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule
